// File: rtl/ekf_pkg.sv
// ekf_pkg: shared types, constants and fixed-point resize helper.
// EKF_OBS_SAT_EN selects saturating instead of wrapping resize.
package ekf_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_UPD,
    S_DONE
  } state_t;

  localparam int STEPS = 14;

  // pi scaled by 2^60, rounded to Q fraction bits on demand
  localparam longint PI_2P60 = 64'sh3243F6A8885A308D;

  function automatic longint pi_q(input int q);
    return (PI_2P60 + (64'sd1 <<< (59 - q))) >>> (60 - q);
  endfunction

  function automatic longint two_pi_q(input int q);
    return (2 * PI_2P60 + (64'sd1 <<< (59 - q))) >>> (60 - q);
  endfunction

  // fit a wide value into n bits; result is sign-extended to 64
  function automatic logic signed [63:0] ekf_fit(
    input logic signed [127:0] v,
    input int                  n
  );
    logic signed [127:0] r;
`ifdef EKF_OBS_SAT_EN
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (n - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
`else
    r = (v <<< (128 - n)) >>> (128 - n);
`endif
    return 64'(r);
  endfunction

endpackage

// File: rtl/ekf_seq_observer_qmul.sv
// Shared fixed-point multiplier: (a*b) >>> Q resized to N bits.
// Resize saturates when EKF_OBS_SAT_EN is defined, else wraps.
module ekf_seq_observer_qmul
  import ekf_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic signed [N-1:0] p
);

  logic signed [2*N-1:0] prod;

  // full product, floor shift, resize
  always_comb begin
    prod = (2*N)'(a) * (2*N)'(b);
    p    = N'(ekf_fit(128'(prod >>> Q), N));
  end

endmodule

// File: rtl/ekf_seq_observer.sv
// Time-multiplexed current/speed/angle observer, one shared multiplier.
// Define EKF_OBS_SAT_EN for saturating arithmetic (default wraps).
module ekf_seq_observer
  import ekf_pkg::*;
#(
  parameter int N = 32,
  parameter int Q = 18
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] valpha,
  input  logic signed [N-1:0] vbeta,
  input  logic signed [N-1:0] ialpham,
  input  logic signed [N-1:0] ibetam,
  input  logic signed [N-1:0] ctheta,
  input  logic signed [N-1:0] stheta,
  input  logic signed [N-1:0] R,
  input  logic signed [N-1:0] GV,
  input  logic signed [N-1:0] GE,
  input  logic signed [N-1:0] K,
  input  logic signed [N-1:0] KW,
  input  logic signed [N-1:0] TS,
  input  logic [31:0]         nbSamples,
  output logic                out_valid,
  output logic                done,
  output logic signed [N-1:0] ialphak,
  output logic signed [N-1:0] ibetak,
  output logic signed [N-1:0] omega,
  output logic signed [N-1:0] theta,
  output logic [31:0]         sample_cnt
);

  localparam logic signed [N-1:0] PI_Q     = N'(pi_q(Q));
  localparam logic signed [N-1:0] TWO_PI_Q = N'(two_pi_q(Q));
  localparam logic signed [N-1:0] NEG_PI_Q = -PI_Q;

  function automatic logic signed [N-1:0] q_add(
    input logic signed [N-1:0] a,
    input logic signed [N-1:0] b
  );
    return N'(ekf_fit(128'(a) + 128'(b), N));
  endfunction

  function automatic logic signed [N-1:0] q_sub(
    input logic signed [N-1:0] a,
    input logic signed [N-1:0] b
  );
    return N'(ekf_fit(128'(a) - 128'(b), N));
  endfunction

  function automatic logic signed [N-1:0] wrap_angle(
    input logic signed [N-1:0] t
  );
    if (t >= PI_Q) return q_sub(t, TWO_PI_Q);
    if (t < NEG_PI_Q) return q_add(t, TWO_PI_Q);
    return t;
  endfunction

  state_t state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ov_q, ov_d;
  logic        accept, hit;

  logic signed [N-1:0] va_q, vb_q, iam_q, ibm_q, ct_q, st_q;
  logic signed [N-1:0] va_d, vb_d, iam_d, ibm_d, ct_d, st_d;
  logic signed [N-1:0] ta_q, tb_q, ua_q, ub_q, pa_q, pb_q, w_q, th_q;
  logic signed [N-1:0] ta_d, tb_d, ua_d, ub_d, pa_d, pb_d, w_d, th_d;
  logic signed [N-1:0] ia_q, ib_q, om_q, tk_q;
  logic signed [N-1:0] ia_d, ib_d, om_d, tk_d;
  logic signed [N-1:0] ma, mb, m;

  ekf_seq_observer_qmul #(.N(N), .Q(Q)) u_qmul (
    .a(ma),
    .b(mb),
    .p(m)
  );

  assign accept = in_valid & in_ready & ~done;
  assign hit    = (nbSamples != 32'd0) && (cnt_q + 32'd1 == nbSamples);

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      va_q <= '0; vb_q <= '0; iam_q <= '0;
      ibm_q <= '0; ct_q <= '0; st_q <= '0;
      ta_q <= '0; tb_q <= '0; ua_q <= '0; ub_q <= '0;
      pa_q <= '0; pb_q <= '0; w_q <= '0; th_q <= '0;
      ia_q <= '0; ib_q <= '0; om_q <= '0; tk_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      va_q <= va_d; vb_q <= vb_d; iam_q <= iam_d;
      ibm_q <= ibm_d; ct_q <= ct_d; st_q <= st_d;
      ta_q <= ta_d; tb_q <= tb_d; ua_q <= ua_d; ub_q <= ub_d;
      pa_q <= pa_d; pb_q <= pb_d; w_q <= w_d; th_q <= th_d;
      ia_q <= ia_d; ib_q <= ib_d; om_q <= om_d; tk_q <= tk_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = S_MUL;
      S_MUL:  if (step_q == 4'(STEPS - 1)) state_d = S_UPD;
      S_UPD:  state_d = hit ? S_DONE : S_IDLE;
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; ready is held off during the out_valid cycle
  always_comb begin
    in_ready = (state_q == S_IDLE) & ~ov_q;
    done     = (state_q == S_DONE);
  end

  // multiplier operand select by step
  always_comb begin
    ma = '0;
    mb = '0;
    unique case (step_q)
      4'd0:  begin ma = R;  mb = ia_q; end
      4'd1:  begin ma = R;  mb = ib_q; end
      4'd2:  begin ma = om_q; mb = st_q; end
      4'd3:  begin ma = om_q; mb = ct_q; end
      4'd4:  begin ma = GV; mb = q_sub(va_q, ta_q); end
      4'd5:  begin ma = GV; mb = q_sub(vb_q, tb_q); end
      4'd6:  begin ma = GE; mb = ua_q; end
      4'd7:  begin ma = GE; mb = ub_q; end
      4'd8:  begin ma = K;  mb = q_sub(iam_q, pa_q); end
      4'd9:  begin ma = K;  mb = q_sub(ibm_q, pb_q); end
      4'd10: begin ma = q_sub(ibm_q, pb_q); mb = ct_q; end
      4'd11: begin ma = q_sub(iam_q, pa_q); mb = st_q; end
      4'd12: begin ma = KW; mb = q_sub(ua_q, ub_q); end
      4'd13: begin ma = TS; mb = w_q; end
      default: ;
    endcase
  end

  // capture, per-step accumulate, commit
  always_comb begin
    step_d = step_q; cnt_d = cnt_q; ov_d = 1'b0;
    va_d = va_q; vb_d = vb_q; iam_d = iam_q;
    ibm_d = ibm_q; ct_d = ct_q; st_d = st_q;
    ta_d = ta_q; tb_d = tb_q; ua_d = ua_q; ub_d = ub_q;
    pa_d = pa_q; pb_d = pb_q; w_d = w_q; th_d = th_q;
    ia_d = ia_q; ib_d = ib_q; om_d = om_q; tk_d = tk_q;
    if (accept) begin
      step_d = '0;
      va_d = valpha; vb_d = vbeta; iam_d = ialpham;
      ibm_d = ibetam; ct_d = ctheta; st_d = stheta;
    end
    if (state_q == S_MUL) begin
      step_d = step_q + 4'd1;
      unique case (step_q)
        4'd0:  ta_d = m;
        4'd1:  tb_d = m;
        4'd2:  ua_d = m;
        4'd3:  ub_d = m;
        4'd4:  pa_d = q_add(ia_q, m);
        4'd5:  pb_d = q_add(ib_q, m);
        4'd6:  pa_d = q_sub(pa_q, m);
        4'd7:  pb_d = q_add(pb_q, m);
        4'd8:  ta_d = q_add(pa_q, m);
        4'd9:  tb_d = q_add(pb_q, m);
        4'd10: ua_d = m;
        4'd11: ub_d = m;
        4'd12: w_d  = q_add(om_q, m);
        4'd13: th_d = wrap_angle(q_add(tk_q, m));
        default: ;
      endcase
    end
    if (state_q == S_UPD) begin
      ia_d = ta_q; ib_d = tb_q; om_d = w_q; tk_d = th_q;
      cnt_d = cnt_q + 32'd1;
      ov_d  = 1'b1;
    end
  end

  assign out_valid  = ov_q;
  assign ialphak    = ia_q;
  assign ibetak     = ib_q;
  assign omega      = om_q;
  assign theta      = tk_q;
  assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_ekf_seq_observer.sv
// Self-checking bench for ekf_seq_observer against an equation-level model.
// Expectations follow EKF_OBS_SAT_EN when it is defined.
module tb_ekf_seq_observer;

  localparam longint PI_Q = 823550;
  localparam longint TWO_PI_Q = 1647099;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready, out_valid, done;
  logic signed [31:0] valpha, vbeta, ialpham, ibetam, ctheta, stheta;
  logic signed [31:0] R, GV, GE, K, KW, TS;
  logic [31:0] nb_samples;
  logic signed [31:0] ialphak, ibetak, omega, theta;
  logic [31:0] sample_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  longint m_ia, m_ib, m_om, m_th;

  ekf_seq_observer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .valpha(valpha), .vbeta(vbeta),
    .ialpham(ialpham), .ibetam(ibetam),
    .ctheta(ctheta), .stheta(stheta),
    .R(R), .GV(GV), .GE(GE), .K(K), .KW(KW), .TS(TS),
    .nbSamples(nb_samples),
    .out_valid(out_valid), .done(done),
    .ialphak(ialphak), .ibetak(ibetak),
    .omega(omega), .theta(theta),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  function automatic longint fit(input longint v);
`ifdef EKF_OBS_SAT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    return longint'(int'(v));
`endif
  endfunction

  function automatic longint mul(input longint a, input longint b);
    return fit((a * b) >>> 18);
  endfunction

  // one observer update straight from the equations
  function automatic void model_step();
    longint pa, pb, ea, eb, eo, et;
    pa = fit(fit(m_ia + mul(GV, fit(valpha - mul(R, m_ia))))
             - mul(GE, mul(m_om, stheta)));
    pb = fit(fit(m_ib + mul(GV, fit(vbeta - mul(R, m_ib))))
             + mul(GE, mul(m_om, ctheta)));
    ea = fit(pa + mul(K, fit(ialpham - pa)));
    eb = fit(pb + mul(K, fit(ibetam - pb)));
    eo = fit(m_om + mul(KW, fit(mul(fit(ibetam - pb), ctheta)
                                - mul(fit(ialpham - pa), stheta))));
    et = fit(m_th + mul(TS, eo));
    if (et >= PI_Q) et = fit(et - TWO_PI_Q);
    else if (et < -PI_Q) et = fit(et + TWO_PI_Q);
    m_ia = ea; m_ib = eb; m_om = eo; m_th = et;
  endfunction

  function automatic logic signed [31:0] rnd(input int span);
    return 32'($urandom_range(0, 2 * span)) - 32'(span);
  endfunction

  task automatic clear_inputs();
    valpha = 0; vbeta = 0; ialpham = 0; ibetam = 0;
    ctheta = 0; stheta = 0;
    R = 0; GV = 0; GE = 0; K = 0; KW = 0; TS = 0;
    nb_samples = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    m_ia = 0; m_ib = 0; m_om = 0; m_th = 0;
    @(negedge clk);
  endtask

  // handshake one sample; lat = cycles to out_valid, -1 on timeout
  task automatic run_sample(output int lat);
    int w;
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) in_valid = 1'b0;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({out_valid, done, in_ready} !== 3'b001) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b need 001",
               {out_valid, done, in_ready});
    end
    n_cmp++;
    if ({ialphak, ibetak, omega, theta, sample_cnt} !== 160'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d %0d %0d %0d %0d need 0",
               ialphak, ibetak, omega, theta, sample_cnt);
    end
  endtask

  task automatic test_kgain();
    int lat;
    do_reset();
    clear_inputs();
    K = 262144;
    ialpham = 1310720;
    run_sample(lat);
    n_cmp++;
    if (lat !== 16) begin
      n_bad++;
      $display("FAIL kgain_latency: got %0d need 16", lat);
    end
    n_cmp++;
    if ({ialphak, ibetak} !== {32'sd1310720, 32'sd0}) begin
      n_bad++;
      $display("FAIL kgain_est: got %0d %0d need 1310720 0",
               ialphak, ibetak);
    end
  endtask

  task automatic test_integrate();
    int lat;
    do_reset();
    clear_inputs();
    GV = 262144;
    valpha = 524288;
    run_sample(lat);
    n_cmp++;
    if (ialphak !== 32'sd524288) begin
      n_bad++;
      $display("FAIL integ_1: got %0d need 524288", ialphak);
    end
    run_sample(lat);
    n_cmp++;
    if (ialphak !== 32'sd1048576 || sample_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL integ_2: got %0d cnt %0d need 1048576 cnt 2",
               ialphak, sample_cnt);
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_reset();
    clear_inputs();
    KW = 262144; TS = 262144;
    ctheta = 262144; ibetam = 1048576;
    run_sample(lat);
    n_cmp++;
    if (omega !== 32'sd1048576 || theta !== -32'sd598523) begin
      n_bad++;
      $display("FAIL wrap: got omega %0d theta %0d need 1048576 -598523",
               omega, theta);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic signed [31:0] exp_v;
`ifdef EKF_OBS_SAT_EN
    exp_v = 32'sh7FFFFFFF;
`else
    exp_v = 32'sh80000000;
`endif
    do_reset();
    clear_inputs();
    GV = 524288;
    valpha = 32'sh40000000;
    run_sample(lat);
    n_cmp++;
    if (ialphak !== exp_v) begin
      n_bad++;
      $display("FAIL overflow: got %h need %h", ialphak, exp_v);
    end
  endtask

  task automatic test_random();
    int lat;
    do_reset();
    clear_inputs();
    for (int i = 0; i < 10; i++) begin
      if (i < 6) begin
        R = rnd(262144); GV = rnd(262144); GE = rnd(262144);
        K = rnd(262144); KW = rnd(262144); TS = rnd(262144);
        valpha = rnd(2097152); vbeta = rnd(2097152);
        ialpham = rnd(2097152); ibetam = rnd(2097152);
        ctheta = rnd(262144); stheta = rnd(262144);
      end else begin
        R = $urandom; GV = $urandom; GE = $urandom;
        K = $urandom; KW = $urandom; TS = $urandom;
        valpha = $urandom; vbeta = $urandom;
        ialpham = $urandom; ibetam = $urandom;
        ctheta = $urandom; stheta = $urandom;
      end
      model_step();
      run_sample(lat);
      n_cmp++;
      if (lat !== 16) begin
        n_bad++;
        $display("FAIL rand_latency[%0d]: got %0d need 16", i, lat);
      end
      n_cmp++;
      if ({ialphak, ibetak, omega, theta} !==
          {int'(m_ia), int'(m_ib), int'(m_om), int'(m_th)}) begin
        n_bad++;
        $display("FAIL rand_est[%0d]: got %0d %0d %0d %0d need %0d %0d %0d %0d",
                 i, ialphak, ibetak, omega, theta, m_ia, m_ib, m_om, m_th);
      end
      n_cmp++;
      if (sample_cnt !== 32'(i + 1)) begin
        n_bad++;
        $display("FAIL rand_cnt[%0d]: got %0d need %0d",
                 i, sample_cnt, i + 1);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int pulses;
    do_reset();
    clear_inputs();
    K = 262144; GV = 131072; KW = 65536; TS = 262144;
    valpha = 300000; ialpham = 700000; ibetam = -400000;
    ctheta = 200000; stheta = 100000;
    model_step();
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ialpham = -5000000;
    valpha = 9999999;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 1 || sample_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL busy_pulses: got %0d cnt %0d need 1 cnt 1",
               pulses, sample_cnt);
    end
    n_cmp++;
    if ({ialphak, ibetak, omega, theta} !==
        {int'(m_ia), int'(m_ib), int'(m_om), int'(m_th)}) begin
      n_bad++;
      $display("FAIL busy_est: got %0d %0d %0d %0d need %0d %0d %0d %0d",
               ialphak, ibetak, omega, theta, m_ia, m_ib, m_om, m_th);
    end
  endtask

  task automatic test_done();
    int pulses, bad_ready;
    do_reset();
    clear_inputs();
    K = 262144; ialpham = 1000;
    nb_samples = 2;
    pulses = 0;
    bad_ready = 0;
    @(negedge clk);
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
      if (done && in_ready) bad_ready++;
    end
    n_cmp++;
    if (pulses !== 2 || sample_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL done_pulses: got %0d cnt %0d need 2 cnt 2",
               pulses, sample_cnt);
    end
    n_cmp++;
    if ({done, in_ready} !== 2'b10 || bad_ready !== 0) begin
      n_bad++;
      $display("FAIL done_flags: got done %b ready %b (%0d) need 1 0",
               done, in_ready, bad_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    clear_inputs();
    K = 262144; ialpham = 1310720;
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_ctrl: got pulses %0d ready %b need 0 1",
               pulses, in_ready);
    end
    n_cmp++;
    if ({ialphak, ibetak, omega, theta, sample_cnt} !== 160'd0) begin
      n_bad++;
      $display("FAIL midreset_state: got %0d %0d %0d %0d %0d need 0",
               ialphak, ibetak, omega, theta, sample_cnt);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_kgain();
    test_integrate();
    test_wrap();
    test_overflow();
    test_random();
    test_busy_ignore();
    test_done();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
